// File: rtl/sip_phaser_out.sv
// rtl/sip_phaser_out.sv - single-clock behavioural model of the 7-series output phaser core
module sip_phaser_out #(
    parameter real REFCLK_PERIOD = 0.0
) (
    input  logic        FREQREFCLK,
    input  logic        RST,
    input  logic        GSR,
    input  logic [3:0]  CLKOUT_DIV,
    input  logic [3:0]  CLKOUT_DIV_POS,
    input  logic [3:0]  CLKOUT_DIV_ST,
    input  logic [5:0]  COARSE_DELAY,
    input  logic [5:0]  FINE_DELAY,
    input  logic [5:0]  OCLK_DELAY,
    input  logic        COARSE_BYPASS,
    input  logic        CTL_MODE,
    input  logic        DATA_CTL_N,
    input  logic        DATA_RD_CYCLES,
    input  logic        EN_OSERDES_RST,
    input  logic        OCLKDELAY_INV,
    input  logic        PHASER_OUT_EN,
    input  logic        SYNC_IN_DIV_RST,
    input  logic        STG1_BYPASS,
    input  logic        EN_TEST_RING,
    input  logic [1:0]  OUTPUT_CLK_SRC,
    input  logic [10:0] TEST_OPT,
    input  logic        FINEENABLE,
    input  logic        FINEINC,
    input  logic        COARSEENABLE,
    input  logic        COARSEINC,
    input  logic        COUNTERLOADEN,
    input  logic [8:0]  COUNTERLOADVAL,
    input  logic        COUNTERREADEN,
    input  logic        BURSTPENDING,
    input  logic        BURSTPENDINGPHY,
    input  logic [1:0]  ENCALIB,
    input  logic [1:0]  ENCALIBPHY,
    input  logic        SYNCIN,
    input  logic        DIVIDERST,
    input  logic        EDGEADV,
    input  logic        SELFINEOCLKDELAY,
    input  logic        MEMREFCLK,
    input  logic        PHASEREFCLK,
    input  logic        SYSCLK,
    input  logic        SCANCLK,
    input  logic        SCANENB,
    input  logic        SCANIN,
    input  logic        SCANMODEB,
    input  logic [15:0] TESTIN,
    output logic        OCLK,
    output logic        OCLKDIV,
    output logic        OCLKDELAYED,
    output logic        FINEOVERFLOW,
    output logic        COARSEOVERFLOW,
    output logic [8:0]  COUNTERREADVAL,
    output logic        OSERDESRST,
    output logic        RDENABLE,
    output logic [1:0]  DQSBUS,
    output logic [1:0]  CTSBUS,
    output logic [1:0]  DTSBUS,
    output logic        SCANOUT,
    output logic [3:0]  TESTOUT
);

    logic        arst_n;
    logic [3:0]  dcnt_q, dcnt_d;
    logic        syncin_q;
    logic        oclk_q, oclkdiv_q, oclkdly_q;
    logic [62:0] hist_q;
    logic [63:0] hist_all;
    logic [5:0]  fine_q, fine_d, coarse_q, coarse_d, tap;
    logic        fine_ovf_q, fine_ovf_d, coarse_ovf_q, coarse_ovf_d;
    logic [8:0]  tcnt_q, tcnt_d, rdval_q;
    logic [3:0]  osr_cnt_q;
    logic        rden_q;
    logic [1:0]  dqs_q, cts_q, dts_q;
    logic [4:0]  div_n, div_sum;
    logic        sync_edge, burst;
    logic        unused_inputs;

    assign arst_n = RST & ~GSR;

    // hist_all[k] is OCLK k cycles ago; bit 0 is the live toggle register
    assign hist_all = {hist_q, oclk_q};

    always_comb begin
        div_n = (CLKOUT_DIV == 4'hF) ? 5'd16 : ({1'b0, CLKOUT_DIV} + 5'd2);
        div_sum = {1'b0, dcnt_q} + (EDGEADV ? 5'd2 : 5'd1);
        if (div_sum >= div_n) begin
            div_sum = div_sum - div_n;
        end
        sync_edge = SYNCIN & ~syncin_q;
        // a resync load wins over an edge advance in the same cycle
        dcnt_d = (DIVIDERST | (sync_edge & SYNC_IN_DIV_RST)) ? CLKOUT_DIV_ST : div_sum[3:0];

        fine_d     = fine_q;
        fine_ovf_d = 1'b0;
        if (FINEENABLE) begin
            if (FINEINC) begin
                fine_d     = fine_q + 6'd1;
                fine_ovf_d = (fine_q == 6'd63);
            end else begin
                fine_d     = fine_q - 6'd1;
                fine_ovf_d = (fine_q == 6'd0);
            end
        end

        coarse_d     = coarse_q;
        coarse_ovf_d = 1'b0;
        if (COARSE_BYPASS) begin
            coarse_d = 6'd0;
        end else if (COARSEENABLE) begin
            if (COARSEINC) begin
                coarse_d     = coarse_q + 6'd1;
                coarse_ovf_d = (coarse_q == 6'd63);
            end else begin
                coarse_d     = coarse_q - 6'd1;
                coarse_ovf_d = (coarse_q == 6'd0);
            end
        end

        tcnt_d = tcnt_q;
        if (COUNTERLOADEN) begin
            tcnt_d = COUNTERLOADVAL;
        end else if (FINEENABLE) begin
            tcnt_d = FINEINC ? (tcnt_q + 9'd1) : (tcnt_q - 9'd1);
        end

        tap   = SELFINEOCLKDELAY ? fine_q : OCLK_DELAY;
        burst = BURSTPENDING & BURSTPENDINGPHY;
    end

    always_ff @(posedge FREQREFCLK or negedge arst_n) begin
        if (!arst_n) begin
            dcnt_q       <= CLKOUT_DIV_ST;
            syncin_q     <= 1'b0;
            oclk_q       <= 1'b0;
            oclkdiv_q    <= 1'b0;
            oclkdly_q    <= 1'b0;
            hist_q       <= '0;
            fine_q       <= FINE_DELAY;
            coarse_q     <= COARSE_BYPASS ? 6'd0 : COARSE_DELAY;
            fine_ovf_q   <= 1'b0;
            coarse_ovf_q <= 1'b0;
            tcnt_q       <= 9'd0;
            rdval_q      <= 9'd0;
            osr_cnt_q    <= 4'd8;
            rden_q       <= 1'b0;
            dqs_q        <= 2'b00;
            cts_q        <= 2'b11;
            dts_q        <= 2'b11;
        end else if (PHASER_OUT_EN) begin
            dcnt_q       <= dcnt_d;
            syncin_q     <= SYNCIN;
            oclk_q       <= ~oclk_q;
            oclkdiv_q    <= ({1'b0, dcnt_q} < {1'b0, CLKOUT_DIV_POS});
            oclkdly_q    <= hist_all[tap] ^ OCLKDELAY_INV;
            hist_q       <= hist_all[62:0];
            fine_q       <= fine_d;
            coarse_q     <= coarse_d;
            fine_ovf_q   <= fine_ovf_d;
            coarse_ovf_q <= coarse_ovf_d;
            tcnt_q       <= tcnt_d;
            if (COUNTERREADEN) begin
                rdval_q <= tcnt_q;
            end
            if (osr_cnt_q != 4'd0) begin
                osr_cnt_q <= osr_cnt_q - 4'd1;
            end
            rden_q <= DATA_RD_CYCLES & burst & ENCALIB[0] & ENCALIBPHY[0];
            dqs_q  <= burst ? {~oclk_q, oclk_q} : 2'b00;
            cts_q  <= (CTL_MODE & ~DATA_CTL_N & burst) ? 2'b00 : 2'b11;
            dts_q  <= burst ? 2'b00 : 2'b11;
        end
    end

    assign OCLK           = oclk_q;
    assign OCLKDIV        = oclkdiv_q;
    assign OCLKDELAYED    = oclkdly_q;
    assign FINEOVERFLOW   = fine_ovf_q;
    assign COARSEOVERFLOW = coarse_ovf_q;
    assign COUNTERREADVAL = rdval_q;
    assign OSERDESRST     = EN_OSERDES_RST & (osr_cnt_q != 4'd0);
    assign RDENABLE       = rden_q;
    assign DQSBUS         = dqs_q;
    assign CTSBUS         = cts_q;
    assign DTSBUS         = dts_q;
    assign SCANOUT        = 1'b0;
    assign TESTOUT        = 4'd0;

    assign unused_inputs = ^{STG1_BYPASS, EN_TEST_RING, OUTPUT_CLK_SRC, TEST_OPT,
                             ENCALIB[1], ENCALIBPHY[1], MEMREFCLK, PHASEREFCLK, SYSCLK,
                             SCANCLK, SCANENB, SCANIN, SCANMODEB, TESTIN,
                             (REFCLK_PERIOD < 0.0)};

endmodule

// File: tb/tb_sip_phaser_out.sv
// tb/tb_sip_phaser_out.sv - self-checking bench for sip_phaser_out
`timescale 1ns/1ps
module tb_sip_phaser_out;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        RST = 1'b0, GSR = 1'b0;
    logic [3:0]  CLKOUT_DIV, CLKOUT_DIV_POS, CLKOUT_DIV_ST;
    logic [5:0]  COARSE_DELAY, FINE_DELAY, OCLK_DELAY;
    logic        COARSE_BYPASS, CTL_MODE, DATA_CTL_N, DATA_RD_CYCLES, EN_OSERDES_RST;
    logic        OCLKDELAY_INV, PHASER_OUT_EN, SYNC_IN_DIV_RST, STG1_BYPASS, EN_TEST_RING;
    logic [1:0]  OUTPUT_CLK_SRC;
    logic [10:0] TEST_OPT;
    logic        FINEENABLE, FINEINC, COARSEENABLE, COARSEINC, COUNTERLOADEN, COUNTERREADEN;
    logic [8:0]  COUNTERLOADVAL;
    logic        BURSTPENDING, BURSTPENDINGPHY, SYNCIN, DIVIDERST, EDGEADV, SELFINEOCLKDELAY;
    logic [1:0]  ENCALIB, ENCALIBPHY;
    logic        MEMREFCLK, PHASEREFCLK, SYSCLK, SCANCLK, SCANENB, SCANIN, SCANMODEB;
    logic [15:0] TESTIN;
    logic        OCLK, OCLKDIV, OCLKDELAYED, FINEOVERFLOW, COARSEOVERFLOW;
    logic [8:0]  COUNTERREADVAL;
    logic        OSERDESRST, RDENABLE, SCANOUT;
    logic [1:0]  DQSBUS, CTSBUS, DTSBUS;
    logic [3:0]  TESTOUT;

    sip_phaser_out #(.REFCLK_PERIOD(2.5)) dut (
        .FREQREFCLK(clk), .RST(RST), .GSR(GSR),
        .CLKOUT_DIV(CLKOUT_DIV), .CLKOUT_DIV_POS(CLKOUT_DIV_POS), .CLKOUT_DIV_ST(CLKOUT_DIV_ST),
        .COARSE_DELAY(COARSE_DELAY), .FINE_DELAY(FINE_DELAY), .OCLK_DELAY(OCLK_DELAY),
        .COARSE_BYPASS(COARSE_BYPASS), .CTL_MODE(CTL_MODE), .DATA_CTL_N(DATA_CTL_N),
        .DATA_RD_CYCLES(DATA_RD_CYCLES), .EN_OSERDES_RST(EN_OSERDES_RST),
        .OCLKDELAY_INV(OCLKDELAY_INV), .PHASER_OUT_EN(PHASER_OUT_EN),
        .SYNC_IN_DIV_RST(SYNC_IN_DIV_RST), .STG1_BYPASS(STG1_BYPASS), .EN_TEST_RING(EN_TEST_RING),
        .OUTPUT_CLK_SRC(OUTPUT_CLK_SRC), .TEST_OPT(TEST_OPT),
        .FINEENABLE(FINEENABLE), .FINEINC(FINEINC), .COARSEENABLE(COARSEENABLE), .COARSEINC(COARSEINC),
        .COUNTERLOADEN(COUNTERLOADEN), .COUNTERLOADVAL(COUNTERLOADVAL), .COUNTERREADEN(COUNTERREADEN),
        .BURSTPENDING(BURSTPENDING), .BURSTPENDINGPHY(BURSTPENDINGPHY),
        .ENCALIB(ENCALIB), .ENCALIBPHY(ENCALIBPHY),
        .SYNCIN(SYNCIN), .DIVIDERST(DIVIDERST), .EDGEADV(EDGEADV), .SELFINEOCLKDELAY(SELFINEOCLKDELAY),
        .MEMREFCLK(MEMREFCLK), .PHASEREFCLK(PHASEREFCLK), .SYSCLK(SYSCLK), .SCANCLK(SCANCLK),
        .SCANENB(SCANENB), .SCANIN(SCANIN), .SCANMODEB(SCANMODEB), .TESTIN(TESTIN),
        .OCLK(OCLK), .OCLKDIV(OCLKDIV), .OCLKDELAYED(OCLKDELAYED),
        .FINEOVERFLOW(FINEOVERFLOW), .COARSEOVERFLOW(COARSEOVERFLOW),
        .COUNTERREADVAL(COUNTERREADVAL), .OSERDESRST(OSERDESRST), .RDENABLE(RDENABLE),
        .DQSBUS(DQSBUS), .CTSBUS(CTSBUS), .DTSBUS(DTSBUS), .SCANOUT(SCANOUT), .TESTOUT(TESTOUT)
    );

    int n_vec = 0;
    int n_bad = 0;

    // reference model state
    int       m_dcnt, m_fine, m_coarse, m_tcnt, m_oscnt, e_rval;
    bit       m_sync, m_oclk;
    bit       m_hist[64];
    bit       e_div, e_od, e_fovf, e_covf, e_rden;
    bit [1:0] e_dqs, e_cts, e_dts;
    bit       oq[$];

    typedef struct {
        bit       fe, finc, ce, cinc, lden, rden;
        bit [8:0] ldval;
        bit       x_fovf, x_covf;
        bit [8:0] x_rval;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_dcnt = CLKOUT_DIV_ST;
        m_fine = FINE_DELAY;
        m_coarse = COARSE_BYPASS ? 0 : COARSE_DELAY;
        m_tcnt = 0; m_oscnt = 8; e_rval = 0;
        m_sync = 0; m_oclk = 0;
        for (int k = 0; k < 64; k++) m_hist[k] = 0;
        e_div = 0; e_od = 0; e_fovf = 0; e_covf = 0; e_rden = 0;
        e_dqs = 2'b00; e_cts = 2'b11; e_dts = 2'b11;
        oq.delete();
        oq.push_back(1'b0);
    endfunction

    function automatic void model_edge();
        int n, tap;
        bit brst, sedge;
        if (!PHASER_OUT_EN) return;
        n = (CLKOUT_DIV == 4'd15) ? 16 : int'(CLKOUT_DIV) + 2;
        brst = BURSTPENDING && BURSTPENDINGPHY;
        tap = SELFINEOCLKDELAY ? m_fine : int'(OCLK_DELAY);
        e_div = (m_dcnt < int'(CLKOUT_DIV_POS));
        e_od = m_hist[tap] ^ OCLKDELAY_INV;
        sedge = SYNCIN && !m_sync;
        m_sync = SYNCIN;
        if (DIVIDERST || (sedge && SYNC_IN_DIV_RST)) m_dcnt = CLKOUT_DIV_ST;
        else m_dcnt = (m_dcnt + (EDGEADV ? 2 : 1)) % n;
        if (COUNTERREADEN) e_rval = m_tcnt;
        if (COUNTERLOADEN) m_tcnt = COUNTERLOADVAL;
        else if (FINEENABLE) m_tcnt = (m_tcnt + (FINEINC ? 1 : 511)) % 512;
        e_fovf = 0;
        if (FINEENABLE) begin
            e_fovf = FINEINC ? (m_fine == 63) : (m_fine == 0);
            m_fine = (m_fine + (FINEINC ? 1 : 63)) % 64;
        end
        e_covf = 0;
        if (COARSE_BYPASS) m_coarse = 0;
        else if (COARSEENABLE) begin
            e_covf = COARSEINC ? (m_coarse == 63) : (m_coarse == 0);
            m_coarse = (m_coarse + (COARSEINC ? 1 : 63)) % 64;
        end
        e_dts = brst ? 2'b00 : 2'b11;
        e_dqs = brst ? {!m_oclk, m_oclk} : 2'b00;
        e_cts = (CTL_MODE && !DATA_CTL_N && brst) ? 2'b00 : 2'b11;
        e_rden = DATA_RD_CYCLES && brst && ENCALIB[0] && ENCALIBPHY[0];
        if (m_oscnt > 0) m_oscnt--;
        for (int k = 63; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_oclk = !m_oclk;
        m_hist[0] = m_oclk;
    endfunction

    task automatic check_all();
        chk("oclk", OCLK, m_oclk);
        chk("oclkdiv", OCLKDIV, e_div);
        chk("oclkdelayed", OCLKDELAYED, e_od);
        chk("fineovf", FINEOVERFLOW, e_fovf);
        chk("coarseovf", COARSEOVERFLOW, e_covf);
        chk("readval", COUNTERREADVAL, e_rval[8:0]);
        chk("oserdesrst", OSERDESRST, EN_OSERDES_RST && (m_oscnt != 0));
        chk("rdenable", RDENABLE, e_rden);
        chk("dqsbus", DQSBUS, e_dqs);
        chk("ctsbus", CTSBUS, e_cts);
        chk("dtsbus", DTSBUS, e_dts);
        chk("scan_test", {TESTOUT, SCANOUT}, 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        oq.push_back(m_oclk);
    endtask

    task automatic idle();
        FINEENABLE = 0; FINEINC = 0; COARSEENABLE = 0; COARSEINC = 0;
        COUNTERLOADEN = 0; COUNTERLOADVAL = 0; COUNTERREADEN = 0;
        BURSTPENDING = 0; BURSTPENDINGPHY = 0; ENCALIB = 0; ENCALIBPHY = 0;
        SYNCIN = 0; DIVIDERST = 0; EDGEADV = 0; SELFINEOCLKDELAY = 0; PHASER_OUT_EN = 1;
    endtask

    task automatic assert_reset(input bit use_gsr);
        @(negedge clk);
        if (use_gsr) GSR = 1; else RST = 0;
        model_reset();
        #2;
        check_all();
    endtask

    task automatic release_reset();
        @(negedge clk);
        RST = 1;
        GSR = 0;
    endtask

    task automatic config_base();
        CLKOUT_DIV = 2; CLKOUT_DIV_POS = 2; CLKOUT_DIV_ST = 0;
        COARSE_DELAY = 5; FINE_DELAY = 62; OCLK_DELAY = 3;
        COARSE_BYPASS = 1; CTL_MODE = 0; DATA_CTL_N = 1; DATA_RD_CYCLES = 0;
        EN_OSERDES_RST = 1; OCLKDELAY_INV = 0; SYNC_IN_DIV_RST = 0;
        STG1_BYPASS = 0; EN_TEST_RING = 0; OUTPUT_CLK_SRC = 0; TEST_OPT = 0;
        MEMREFCLK = 0; PHASEREFCLK = 0; SYSCLK = 0; SCANCLK = 0; SCANENB = 0;
        SCANIN = 0; SCANMODEB = 0; TESTIN = 0;
    endtask

    initial begin
        bit sv[10], av[10], dv[10];
        int n;
        config_base();
        idle();

        // divider pattern, OSERDES reset length, reset values
        assert_reset(0);
        chk("rst_oclkdiv", OCLKDIV, 0);
        chk("rst_dts", DTSBUS, 2'b11);
        chk("rst_cts", CTSBUS, 2'b11);
        chk("rst_dqs", DQSBUS, 2'b00);
        chk("rst_osr", OSERDESRST, 1);
        chk("rst_rden", RDENABLE, 0);
        chk("rst_rval", COUNTERREADVAL, 0);
        release_reset();
        for (int i = 1; i <= 12; i++) begin
            step();
            chk("div_pattern", OCLKDIV, ((i - 1) % 4) < 2);
            chk("osr_length", OSERDESRST, i <= 7);
            if (i >= 4) chk("oclk_delay3", OCLKDELAYED, oq[oq.size()-5]);
        end

        // fine/coarse/tap table, starting from fine = 62, tcnt = 0, coarse bypassed
        tbl[0]  = '{1,1,1,1,0,0,9'h000, 0,0,9'h000};
        tbl[1]  = '{1,1,1,1,0,0,9'h000, 1,0,9'h000};
        tbl[2]  = '{1,1,1,0,0,0,9'h000, 0,0,9'h000};
        tbl[3]  = '{1,0,1,0,0,0,9'h000, 0,0,9'h000};
        tbl[4]  = '{1,0,0,0,0,0,9'h000, 1,0,9'h000};
        tbl[5]  = '{0,0,1,0,0,1,9'h000, 0,0,9'h001};
        tbl[6]  = '{0,0,0,0,1,0,9'h1FF, 0,0,9'h001};
        tbl[7]  = '{1,1,1,1,0,0,9'h000, 1,0,9'h001};
        tbl[8]  = '{0,0,0,0,0,1,9'h000, 0,0,9'h000};
        tbl[9]  = '{0,0,0,0,1,1,9'h055, 0,0,9'h000};
        tbl[10] = '{0,0,0,0,0,1,9'h000, 0,0,9'h055};
        for (int i = 0; i < 11; i++) begin
            FINEENABLE = tbl[i].fe; FINEINC = tbl[i].finc;
            COARSEENABLE = tbl[i].ce; COARSEINC = tbl[i].cinc;
            COUNTERLOADEN = tbl[i].lden; COUNTERLOADVAL = tbl[i].ldval;
            COUNTERREADEN = tbl[i].rden;
            step();
            chk($sformatf("tbl%0d_fovf", i), FINEOVERFLOW, tbl[i].x_fovf);
            chk($sformatf("tbl%0d_covf", i), COARSEOVERFLOW, tbl[i].x_covf);
            chk($sformatf("tbl%0d_rval", i), COUNTERREADVAL, tbl[i].x_rval);
        end
        idle();

        // inverted delayed clock
        OCLKDELAYED_INV_SET: begin
            OCLKDELAY_INV = 1;
            for (int i = 0; i < 6; i++) begin
                step();
                chk("oclk_delay3_inv", OCLKDELAYED, !oq[oq.size()-5]);
            end
            OCLKDELAY_INV = 0;
        end

        // burst, then asynchronous reset in mid-burst
        BURSTPENDING = 1; BURSTPENDINGPHY = 1; DATA_RD_CYCLES = 1;
        ENCALIB = 2'b01; ENCALIBPHY = 2'b01; CTL_MODE = 1; DATA_CTL_N = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("burst_dts", DTSBUS, 2'b00);
            chk("burst_rden", RDENABLE, 1);
            chk("burst_cts", CTSBUS, 2'b00);
            chk("burst_dqs", DQSBUS, {!oq[oq.size()-2], oq[oq.size()-2]});
        end
        #2;
        RST = 0;
        #1;
        chk("async_dts", DTSBUS, 2'b11);
        chk("async_rden", RDENABLE, 0);
        chk("async_dqs", DQSBUS, 2'b00);
        chk("async_oclk", OCLK, 0);
        chk("async_osr", OSERDESRST, 1);
        model_reset();
        check_all();
        release_reset();
        idle();
        CTL_MODE = 0; DATA_CTL_N = 1; DATA_RD_CYCLES = 0;
        for (int i = 0; i < 3; i++) step();

        // SYNCIN edge with EDGEADV in the same cycle loses the advance
        CLKOUT_DIV_ST = 2; SYNC_IN_DIV_RST = 1;
        assert_reset(0);
        release_reset();
        sv = '{0,0,0,1,1,0,0,0,0,0};
        av = '{0,0,0,1,0,0,0,1,0,0};
        dv = '{0,0,1,1,0,0,1,1,0,1};
        for (int i = 0; i < 10; i++) begin
            SYNCIN = sv[i];
            EDGEADV = av[i];
            step();
            chk($sformatf("sync_adv%0d", i), OCLKDIV, dv[i]);
        end
        idle();

        // randomized runs against the reference model
        for (int r = 0; r < 6; r++) begin
            CLKOUT_DIV = 4'($urandom);
            n = (CLKOUT_DIV == 4'd15) ? 16 : int'(CLKOUT_DIV) + 2;
            CLKOUT_DIV_ST = 4'($urandom_range(n - 1, 0));
            CLKOUT_DIV_POS = 4'($urandom);
            COARSE_DELAY = 6'($urandom); FINE_DELAY = 6'($urandom); OCLK_DELAY = 6'($urandom);
            COARSE_BYPASS = 1'($urandom); CTL_MODE = 1'($urandom); DATA_CTL_N = 1'($urandom);
            DATA_RD_CYCLES = 1'($urandom); EN_OSERDES_RST = 1'($urandom);
            OCLKDELAY_INV = 1'($urandom); SYNC_IN_DIV_RST = 1'($urandom);
            TEST_OPT = 11'($urandom); TESTIN = 16'($urandom);
            assert_reset(r[0]);
            release_reset();
            for (int c = 0; c < 400; c++) begin
                FINEENABLE = ($urandom % 3) == 0; FINEINC = 1'($urandom);
                COARSEENABLE = ($urandom % 3) == 0; COARSEINC = 1'($urandom);
                COUNTERLOADEN = ($urandom % 8) == 0; COUNTERLOADVAL = 9'($urandom);
                COUNTERREADEN = ($urandom % 3) == 0;
                BURSTPENDING = 1'($urandom); BURSTPENDINGPHY = 1'($urandom);
                ENCALIB = 2'($urandom); ENCALIBPHY = 2'($urandom);
                SYNCIN = 1'($urandom); DIVIDERST = ($urandom % 16) == 0;
                EDGEADV = ($urandom % 4) == 0; SELFINEOCLKDELAY = 1'($urandom);
                PHASER_OUT_EN = ($urandom % 10) != 0;
                SCANIN = 1'($urandom); SYSCLK = 1'($urandom);
                step();
            end
            idle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
